// File: rtl/knn_pkg.sv
// Shared types and sizing for the k-NN result reader: point layout, packed
// result vector, FSM state encoding and the entry-extraction helper.
package knn_pkg;

  localparam int W     = 32;
  localparam int K     = 8;
  localparam int CW    = 16;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int VEC_W = 2 * W * K;

  // x sits in the upper half so a point matches one slice of the core's result bus.
  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } point_t;

  typedef logic [K-1:0][2*W-1:0] knn_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_EMIT    = 2'd3
  } knn_state_e;

  function automatic point_t knn_get_entry(input knn_vec_t vec,
                                           input logic [IDX_W-1:0] idx);
    return point_t'(vec[idx]);
  endfunction

endpackage

// File: rtl/knn_entry_mux.sv
// Combinational K:1 selector picking one snapshot entry by rank.
module knn_entry_mux
  import knn_pkg::*;
(
  input  logic [VEC_W-1:0] i_vec,
  input  logic [IDX_W-1:0] i_rank,
  output point_t           o_pt
);

  always_comb begin
    o_pt = knn_get_entry(knn_vec_t'(i_vec), i_rank);
  end

endmodule

// File: rtl/k_nns_result_reader.sv
// Counts points of one k-NN search, snapshots the core's result vector and
// streams the min(n_points, K) entries out. KNN_RD_REVERSE_EN: farthest-first.
module k_nns_result_reader
  import knn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    n_points,
  input  logic             pt_valid,
  input  logic [VEC_W-1:0] knn_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_x,
  output logic [W-1:0]     out_y,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output knn_state_e       dbg_state
);

  // Output stream: a beat transfers on a cycle where out_valid && out_ready;
  // once raised, out_valid and the payload hold until that transfer happens.

  knn_state_e       r_state;
  knn_state_e       w_state_nxt;
  logic [CW-1:0]    r_n;
  logic [CW-1:0]    r_e;
  logic [CW-1:0]    r_cnt;
  logic [VEC_W-1:0] r_snap;
  logic [IDX_W-1:0] r_rank;
  logic             r_done;

  logic [CW-1:0]    w_cnt_inc;
  logic             w_fire;
  logic             w_last;
  logic [IDX_W-1:0] w_rank_first;
  logic [IDX_W-1:0] w_rank_next;
  point_t           w_pt;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_fire    = (r_state == ST_EMIT) && out_ready;

`ifdef KNN_RD_REVERSE_EN
  assign w_rank_first = IDX_W'(r_e - CW'(1));
  assign w_rank_next  = r_rank - IDX_W'(1);
  assign w_last       = (r_rank == '0);
`else
  assign w_rank_first = '0;
  assign w_rank_next  = r_rank + IDX_W'(1);
  assign w_last       = (CW'(r_rank) == (r_e - CW'(1)));
`endif

  knn_entry_mux u_mux (
    .i_vec  (r_snap),
    .i_rank (r_rank),
    .o_pt   (w_pt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start && (n_points != '0)) w_state_nxt = ST_SCAN;
      ST_SCAN:    if (pt_valid && (w_cnt_inc == r_n)) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_EMIT;
      ST_EMIT:    if (w_fire && w_last) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n    <= '0;
      r_e    <= '0;
      r_cnt  <= '0;
      r_snap <= '0;
      r_rank <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= ((r_state == ST_IDLE) && start && (n_points == '0)) || (w_fire && w_last);
      if ((r_state == ST_IDLE) && start) begin
        r_n   <= n_points;
        r_e   <= (n_points < CW'(K)) ? n_points : CW'(K);
        r_cnt <= '0;
      end
      if ((r_state == ST_SCAN) && pt_valid) r_cnt <= w_cnt_inc;
      // knn_in is only trusted one cycle after the final point was absorbed.
      if (r_state == ST_CAPTURE) begin
        r_snap <= knn_in;
        r_rank <= w_rank_first;
      end
      if (w_fire && !w_last) r_rank <= w_rank_next;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_x     = '0;
    out_y     = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (r_state == ST_EMIT) begin
      out_valid = 1'b1;
      out_x     = w_pt.x;
      out_y     = w_pt.y;
      out_idx   = r_rank;
      out_last  = w_last;
    end
    busy      = (r_state != ST_IDLE);
    done      = r_done;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_k_nns_result_reader.sv
// Directed bench for k_nns_result_reader: full/short/empty searches, stalls,
// mid-emit reset and back-to-back starts, with hand-derived expected beats.
module tb_k_nns_result_reader;
  import knn_pkg::*;

`ifdef KNN_RD_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CW-1:0]    n_points;
  logic             pt_valid;
  logic [VEC_W-1:0] knn_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_x;
  logic [W-1:0]     out_y;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;
  logic             done;
  knn_state_e       dbg_state;

  int errors = 0;
  int checks = 0;

  k_nns_result_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_points  (n_points),
    .pt_valid  (pt_valid),
    .knn_in    (knn_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry r of a vector built from base: x = base+16r+1, y = base+16r+2.
  function automatic knn_vec_t mk_vec(input logic [31:0] base, input int nfill);
    knn_vec_t v;
    v = '0;
    for (int r = 0; r < K; r++)
      if (r < nfill) v[r] = {base + 32'(16 * r) + 32'd1, base + 32'(16 * r) + 32'd2};
    return v;
  endfunction

  task automatic do_start(input int n);
    start    = 1'b1;
    n_points = CW'(n);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Streams n valid points (with idle gaps), then presents the final result.
  task automatic send_points(input int n, input knn_vec_t final_vec, input bit poke_start);
    for (int i = 0; i < n; i++) begin
      if ((i % 4) == 3) begin
        pt_valid = 1'b0;
        @(posedge clk); #1;
      end
      knn_in   = mk_vec(32'h5555_0000 + 32'(i), K);
      pt_valid = 1'b1;
      start    = poke_start && (i == 2);
      n_points = poke_start ? CW'(5) : n_points;
      @(posedge clk); #1;
      start    = 1'b0;
    end
    pt_valid = 1'b0;
    knn_in   = final_vec;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL capture_cycle: out_valid=%b busy=%b, want 0/1", out_valid, busy); end
    @(posedge clk); #1;
    knn_in = mk_vec(32'hBAD0_0000, K);
  endtask

  task automatic drain(input int e, input logic [31:0] base, input bit stall);
    int beats;
    int c;
    int rank;
    bit rdy;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    beats = 0;
    c = 0;
    while (beats < e && c < 64) begin
      rdy = stall ? (((c % 4) == 0) || ((c % 4) == 3)) : 1'b1;
      out_ready = rdy;
      if (stall) knn_in = mk_vec(32'hDEAD_0000 + 32'(c), K);
      @(negedge clk);
      rank = REV ? (e - 1 - beats) : beats;
      ex = base + 32'(16 * rank) + 32'd1;
      ey = base + 32'(16 * rank) + 32'd2;
      checks++;
      if (out_valid !== 1'b1 || done !== 1'b0)
        begin errors++; $display("FAIL emit_valid: beat=%0d out_valid=%b done=%b, want 1/0", beats, out_valid, done); end
      checks++;
      if (out_x !== ex || out_y !== ey || out_idx !== IDX_W'(rank) || out_last !== (beats == e - 1))
        begin
          errors++;
          $display("FAIL emit_data: beat=%0d got x=%h y=%h idx=%0d last=%b, want x=%h y=%h idx=%0d last=%b",
                   beats, out_x, out_y, out_idx, out_last, ex, ey, rank, (beats == e - 1));
        end
      if (rdy) beats++;
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b1;
    checks++;
    if (beats != e)
      begin errors++; $display("FAIL emit_timeout: beats=%0d, want %0d", beats, e); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL done_pulse: done=%b out_valid=%b busy=%b, want 1/0/0", done, out_valid, busy); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; n_points = '0; pt_valid = 1'b0; knn_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_x, out_y, out_idx, out_last, busy, done} !== '0 || dbg_state !== ST_IDLE)
      begin errors++; $display("FAIL reset_outputs: valid=%b x=%h y=%h busy=%b done=%b st=%0d, want all 0",
                               out_valid, out_x, out_y, busy, done, dbg_state); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full;
    do_start(20);
    send_points(20, mk_vec(32'h1000_0000, K), 1'b1);
    drain(8, 32'h1000_0000, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0)
      begin errors++; $display("FAIL done_width: done=%b, want 0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_short;
    do_start(3);
    send_points(3, mk_vec(32'h2000_0000, 3), 1'b0);
    drain(3, 32'h2000_0000, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    start = 1'b1;
    n_points = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL zero_pre: busy=%b done=%b, want 0/0", busy, done); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL zero_done: done=%b busy=%b out_valid=%b, want 1/0/0", done, busy, out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL zero_after: done=%b busy=%b out_valid=%b, want 0/0/0", done, busy, out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    do_start(11);
    send_points(11, mk_vec(32'h3000_0000, K), 1'b0);
    drain(8, 32'h3000_0000, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    do_start(12);
    send_points(12, mk_vec(32'h4000_0000, K), 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== (REV ? IDX_W'(6) : IDX_W'(1)))
      begin errors++; $display("FAIL abort_second_beat: valid=%b idx=%0d", out_valid, out_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_x, out_y, out_idx, out_last, busy, done} !== '0)
      begin errors++; $display("FAIL abort_async: valid=%b x=%h y=%h idx=%0d busy=%b done=%b, want all 0",
                               out_valid, out_x, out_y, out_idx, busy, done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL abort_no_done: done=%b busy=%b, want 0/0", done, busy); end
    @(posedge clk); #1;
    do_start(10);
    send_points(10, mk_vec(32'h5000_0000, K), 1'b0);
    drain(8, 32'h5000_0000, 1'b0);
    @(posedge clk); #1;
  endtask

  // A start during the done-pulse cycle must be taken.
  task automatic test_back_to_back;
    do_start(9);
    send_points(9, mk_vec(32'h6000_0000, K), 1'b0);
    drain(8, 32'h6000_0000, 1'b0);
    start = 1'b1;
    n_points = CW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dbg_state !== ST_SCAN)
      begin errors++; $display("FAIL b2b_accept: busy=%b st=%0d, want 1/%0d", busy, dbg_state, ST_SCAN); end
    @(posedge clk); #1;
    send_points(2, mk_vec(32'h7000_0000, 2), 1'b0);
    drain(2, 32'h7000_0000, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full();
    test_short();
    test_zero();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
